// File: rtl/pad_bank_ctrl_if.sv
// Pad-bank bundle: core-side controls plus the pad-cell A/EN/Y pins.
// master = core/pad-ring side, slave = pad_bank_ctrl.
interface pad_bank_ctrl_if #(
  parameter int N_CH  = 8,
  parameter int DEB_W = 4
);
  logic [N_CH-1:0]  dout;
  logic [N_CH-1:0]  dir;
  logic [DEB_W-1:0] deb_len;
  logic [N_CH-1:0]  pad_a;
  logic [N_CH-1:0]  pad_en_n;
  logic [N_CH-1:0]  pad_y;
  logic [N_CH-1:0]  din;
  logic [N_CH-1:0]  rise;
  logic [N_CH-1:0]  fall;
  logic [N_CH-1:0]  busy;

  modport master (
    output dout, dir, deb_len, pad_y,
    input  pad_a, pad_en_n, din, rise, fall, busy
  );

  modport slave (
    input  dout, dir, deb_len, pad_y,
    output pad_a, pad_en_n, din, rise, fall, busy
  );
endinterface

// File: rtl/pad_bank_ctrl.sv
// Per-channel bidirectional pad control: registered output, break-before-make direction FSM,
// synchronised + debounced input with edge pulses. Outputs are registered; no backpressure.
module pad_bank_ctrl #(
  parameter int N_CH        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 4,
  parameter int TURN_CYC    = 2
) (
  input  logic           clk,
  input  logic           rst,
  pad_bank_ctrl_if.slave bus
);
  localparam int            TW    = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TURN_CYC - 1);

  typedef enum logic [1:0] {
    ST_IN       = 2'd0,
    ST_TURN_OUT = 2'd1,
    ST_OUT      = 2'd2,
    ST_TURN_IN  = 2'd3
  } state_t;

  logic [N_CH-1:0] r_pad_a;
  logic [N_CH-1:0] r_sync [SYNC_STAGES];
  logic [N_CH-1:0] w_sy;
  logic [N_CH-1:0] w_en_n;
  logic [N_CH-1:0] w_busy;
  logic [N_CH-1:0] w_din;
  logic [N_CH-1:0] w_rise;
  logic [N_CH-1:0] w_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pad_a <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_pad_a   <= bus.dout;
      r_sync[0] <= bus.pad_y;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_sy = r_sync[SYNC_STAGES-1];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t           r_st;
    logic [TW-1:0]    r_tcnt;
    logic             r_en_n;
    logic             r_busy;
    logic [DEB_W-1:0] r_cnt;
    logic             r_din;
    logic             r_rise;
    logic             r_fall;

    // Any entry into a turnaround restarts tcnt, so the driver is always off for TURN_CYC edges.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_st   <= ST_IN;
        r_tcnt <= '0;
        r_en_n <= 1'b1;
        r_busy <= 1'b0;
      end else begin
        case (r_st)
          ST_IN: begin
            if (bus.dir[i]) begin
              r_st   <= ST_TURN_OUT;
              r_tcnt <= '0;
              r_busy <= 1'b1;
            end
          end
          ST_TURN_OUT: begin
            if (!bus.dir[i]) begin
              r_st   <= ST_IN;
              r_busy <= 1'b0;
            end else if (r_tcnt == TLAST) begin
              r_st   <= ST_OUT;
              r_en_n <= 1'b0;
              r_busy <= 1'b0;
            end else begin
              r_tcnt <= r_tcnt + TW'(1);
            end
          end
          ST_OUT: begin
            if (!bus.dir[i]) begin
              r_st   <= ST_TURN_IN;
              r_tcnt <= '0;
              r_en_n <= 1'b1;
              r_busy <= 1'b1;
            end
          end
          ST_TURN_IN: begin
            if (bus.dir[i]) begin
              r_st   <= ST_TURN_OUT;
              r_tcnt <= '0;
            end else if (r_tcnt == TLAST) begin
              r_st   <= ST_IN;
              r_busy <= 1'b0;
            end else begin
              r_tcnt <= r_tcnt + TW'(1);
            end
          end
          default: begin
            r_st   <= ST_IN;
            r_en_n <= 1'b1;
            r_busy <= 1'b0;
          end
        endcase
      end
    end

    // Frozen while the bus floats after release, so the transient never reaches din.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt  <= '0;
        r_din  <= 1'b0;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end else begin
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        if (r_st == ST_TURN_IN) begin
          r_cnt <= '0;
        end else if (w_sy[i] == r_din) begin
          r_cnt <= '0;
        end else if (r_cnt >= bus.deb_len) begin
          r_din  <= w_sy[i];
          r_rise <= w_sy[i];
          r_fall <= ~w_sy[i];
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + DEB_W'(1);
        end
      end
    end

    assign w_en_n[i] = r_en_n;
    assign w_busy[i] = r_busy;
    assign w_din[i]  = r_din;
    assign w_rise[i] = r_rise;
    assign w_fall[i] = r_fall;
  end

  assign bus.pad_a    = r_pad_a;
  assign bus.pad_en_n = w_en_n;
  assign bus.busy     = w_busy;
  assign bus.din      = w_din;
  assign bus.rise     = w_rise;
  assign bus.fall     = w_fall;
endmodule

// File: tb/tb_pad_bank_ctrl.sv
// Bench for pad_bank_ctrl: directed vector table, hand sequences, then random stimulus vs a history-based model.
module tb_pad_bank_ctrl;
  localparam int N_CH        = 8;
  localparam int SYNC_STAGES = 2;
  localparam int DEB_W       = 4;
  localparam int TURN_CYC    = 2;

  logic clk;
  logic rst;

  pad_bank_ctrl_if #(.N_CH(N_CH), .DEB_W(DEB_W)) bus ();

  pad_bank_ctrl #(
    .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .DEB_W(DEB_W), .TURN_CYC(TURN_CYC)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference model: direction from run lengths of sampled dir, input from a delay line plus disagreement streak.
  int              m_ones   [N_CH];
  int              m_zeros  [N_CH];
  bit              m_fromout[N_CH];
  int              m_streak [N_CH];
  logic [N_CH-1:0] m_sq     [SYNC_STAGES];
  logic [N_CH-1:0] m_pad_a, m_din, m_rise, m_fall;

  task automatic reset_model();
    for (int c = 0; c < N_CH; c++) begin
      m_ones[c] = 0; m_zeros[c] = 0; m_fromout[c] = 0; m_streak[c] = 0;
    end
    for (int s = 0; s < SYNC_STAGES; s++) m_sq[s] = '0;
    m_pad_a = '0; m_din = '0; m_rise = '0; m_fall = '0;
  endtask

  function automatic bit m_turn_in(input int c);
    return m_fromout[c] && (m_zeros[c] >= 1) && (m_zeros[c] <= TURN_CYC);
  endfunction

  function automatic logic [N_CH-1:0] m_en_n();
    logic [N_CH-1:0] v;
    for (int c = 0; c < N_CH; c++) v[c] = !(m_ones[c] >= TURN_CYC + 1);
    return v;
  endfunction

  function automatic logic [N_CH-1:0] m_busy();
    logic [N_CH-1:0] v;
    for (int c = 0; c < N_CH; c++)
      v[c] = ((m_ones[c] >= 1) && (m_ones[c] <= TURN_CYC)) || m_turn_in(c);
    return v;
  endfunction

  task automatic model_edge();
    logic [N_CH-1:0] sy;
    sy = m_sq[SYNC_STAGES-1];
    m_pad_a = bus.dout;
    for (int c = 0; c < N_CH; c++) begin
      m_rise[c] = 1'b0;
      m_fall[c] = 1'b0;
      if (m_turn_in(c)) m_streak[c] = 0;
      else if (sy[c] == m_din[c]) m_streak[c] = 0;
      else if (m_streak[c] >= int'(bus.deb_len)) begin
        m_din[c]  = sy[c];
        m_rise[c] = sy[c];
        m_fall[c] = !sy[c];
        m_streak[c] = 0;
      end else m_streak[c]++;
      if (bus.dir[c]) begin
        if (m_ones[c] < 1000) m_ones[c]++;
        m_zeros[c] = 0;
        m_fromout[c] = 0;
      end else begin
        if (m_ones[c] >= TURN_CYC + 1) m_fromout[c] = 1;
        m_ones[c] = 0;
        if (m_zeros[c] < 1000) m_zeros[c]++;
      end
    end
    for (int s = SYNC_STAGES - 1; s > 0; s--) m_sq[s] = m_sq[s-1];
    m_sq[0] = bus.pad_y;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  typedef struct {
    int         ch;
    logic       dir;
    logic       py;
    logic [3:0] dl;
    logic       e_en_n;
    logic       e_busy;
    logic       e_din;
    logic       e_rise;
    logic       e_fall;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int ch, input logic d, input logic py, input logic [3:0] dl,
                     input logic en, input logic bz, input logic di, input logic ri, input logic fa);
    vec_t v;
    v.ch = ch; v.dir = d; v.py = py; v.dl = dl;
    v.e_en_n = en; v.e_busy = bz; v.e_din = di; v.e_rise = ri; v.e_fall = fa;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1;
    bus.dout = '0; bus.dir = '0; bus.pad_y = '0; bus.deb_len = '0;
    reset_model();
    #1;
    check("rst pad_en_n", 32'(bus.pad_en_n), 32'hff);
    check("rst pad_a", 32'(bus.pad_a), 0);
    check("rst din", 32'(bus.din), 0);
    check("rst rise", 32'(bus.rise), 0);
    check("rst fall", 32'(bus.fall), 0);
    check("rst busy", 32'(bus.busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Turnaround on ch0: 2 busy cycles, drive on 3rd edge; release after 1 edge, then 2 busy.
    add(0, 1, 0, 0, 1, 1, 0, 0, 0);
    add(0, 1, 0, 0, 1, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    // Aborted TURN_OUT on ch1.
    add(1, 1, 0, 0, 1, 1, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0, 0);
    // ch2, deb_len=4: 3-cycle glitch rejected, then stable edges land 7 edges late.
    for (int k = 0; k < 3; k++) add(2, 0, 1, 4, 1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(2, 0, 0, 4, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) add(2, 0, 1, 4, 1, 0, k >= 7, k == 7, 0);
    for (int k = 1; k <= 8; k++) add(2, 0, 0, 4, 1, 0, k < 7, 0, k == 7);
    // ch4, deb_len=0: toggle every 4 cycles, din follows 3 edges late.
    for (int k = 1; k <= 4; k++) add(4, 0, 1, 0, 1, 0, k >= 3, k == 3, 0);
    for (int k = 1; k <= 4; k++) add(4, 0, 0, 0, 1, 0, k < 3, 0, k == 3);
    for (int k = 1; k <= 4; k++) add(4, 0, 1, 0, 1, 0, k >= 3, k == 3, 0);

    for (int r = 0; r < tbl.size(); r++) begin
      bus.dir[tbl[r].ch]   = tbl[r].dir;
      bus.pad_y[tbl[r].ch] = tbl[r].py;
      bus.deb_len          = tbl[r].dl;
      step();
      check($sformatf("row%0d en_n", r), 32'(bus.pad_en_n[tbl[r].ch]), 32'(tbl[r].e_en_n));
      check($sformatf("row%0d busy", r), 32'(bus.busy[tbl[r].ch]), 32'(tbl[r].e_busy));
      check($sformatf("row%0d din", r), 32'(bus.din[tbl[r].ch]), 32'(tbl[r].e_din));
      check($sformatf("row%0d rise", r), 32'(bus.rise[tbl[r].ch]), 32'(tbl[r].e_rise));
      check($sformatf("row%0d fall", r), 32'(bus.fall[tbl[r].ch]), 32'(tbl[r].e_fall));
    end

    // ch3: pad_y pulse during TURN_IN must not reach din; afterwards normal timing.
    bus.deb_len = 0;
    bus.dir[3] = 1'b1;
    repeat (4) step();
    check("t6 driven", 32'(bus.pad_en_n[3]), 0);
    bus.dir[3] = 1'b0; bus.pad_y[3] = 1'b1;
    step();
    check("t6 turn_in busy", 32'(bus.busy[3]), 1);
    bus.pad_y[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("t6 frozen din%0d", k), 32'(bus.din[3]), 0);
      check($sformatf("t6 frozen rise%0d", k), 32'(bus.rise[3]), 0);
    end
    bus.pad_y[3] = 1'b1;
    step(); step();
    check("t6 settle early", 32'(bus.din[3]), 0);
    step();
    check("t6 settle din", 32'(bus.din[3]), 1);
    check("t6 settle rise", 32'(bus.rise[3]), 1);

    // Asynchronous reset while every channel drives.
    bus.dir = '1; bus.dout = '1; bus.pad_y = '1; bus.deb_len = 0;
    repeat (5) step();
    check("t1 pre en_n", 32'(bus.pad_en_n), 0);
    check("t1 pre din", 32'(bus.din), 32'hff);
    check("t1 pre pad_a", 32'(bus.pad_a), 32'hff);
    #2 rst = 1'b1;
    #1;
    check("t1 en_n", 32'(bus.pad_en_n), 32'hff);
    check("t1 pad_a", 32'(bus.pad_a), 0);
    check("t1 din", 32'(bus.din), 0);
    check("t1 rise", 32'(bus.rise), 0);
    check("t1 fall", 32'(bus.fall), 0);
    check("t1 busy", 32'(bus.busy), 0);
    bus.dir = '0; bus.dout = '0; bus.pad_y = '0;
    @(negedge clk);
    rst = 1'b0;
    reset_model();

    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc % 150 == 0) bus.deb_len = DEB_W'($urandom_range(0, 5));
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(0, 4) == 0) bus.dir[c] = ~bus.dir[c];
        if ($urandom_range(0, 3) == 0) bus.pad_y[c] = ~bus.pad_y[c];
      end
      bus.dout = N_CH'($urandom);
      step();
      check($sformatf("rnd%0d pad_a", cyc), 32'(bus.pad_a), 32'(m_pad_a));
      check($sformatf("rnd%0d en_n", cyc), 32'(bus.pad_en_n), 32'(m_en_n()));
      check($sformatf("rnd%0d busy", cyc), 32'(bus.busy), 32'(m_busy()));
      check($sformatf("rnd%0d din", cyc), 32'(bus.din), 32'(m_din));
      check($sformatf("rnd%0d rise", cyc), 32'(bus.rise), 32'(m_rise));
      check($sformatf("rnd%0d fall", cyc), 32'(bus.fall), 32'(m_fall));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
